uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 99 +++++++++
 tb/tb_uart_tx_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Issues a one-cycle launch and then blocks further launches for a full frame time.
module uart_tx_arbiter #(
   parameter int  NUM_REQ      = 4,
   parameter int  CLKS_PER_BIT = 434,
   parameter int  FRAME_BITS   = 10,
   parameter int  GUARD_CYCLES = 0,
   localparam int FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS + GUARD_CYCLES,
   localparam int ID_W         = $clog2(NUM_REQ),
   localparam int CNT_W        = $clog2(FRAME_CYCLES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   gnt,
   output logic                 tx_en,
   output logic [7:0]           tx_data,
   output logic                 busy,
   output logic [ID_W-1:0]      cur_id
);

   // state | meaning
   // IDLE  | no frame in flight; arbitrate among pending requests every cycle
   // WAIT  | frame in flight; count down FRAME_CYCLES, requests ignored
   typedef enum logic {IDLE, WAIT} state_t;

   state_t          state;
   logic [ID_W-1:0] rr_ptr;
   logic [CNT_W-1:0] cnt;

   logic [7:0]      req_bytes [NUM_REQ];
   logic [ID_W-1:0] win_id;
   logic            win_found;
   logic [ID_W-1:0] cand;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_bytes[i] = req_data[8*i +: 8];
      end
   end

   // Search starts one past the last winner so a steady requester cannot starve the others.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         gnt     <= '0;
         tx_en   <= 1'b0;
         tx_data <= '0;
         busy    <= 1'b0;
         cur_id  <= ID_W'(NUM_REQ - 1);
         rr_ptr  <= ID_W'(NUM_REQ - 1);
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               gnt   <= '0;
               tx_en <= 1'b0;
               busy  <= 1'b0;
               if (win_found) begin
                  tx_data <= req_bytes[win_id];
                  tx_en   <= 1'b1;
                  gnt     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
                  cur_id  <= win_id;
                  rr_ptr  <= win_id;
                  cnt     <= CNT_W'(FRAME_CYCLES - 1);
                  busy    <= 1'b1;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               gnt   <= '0;
               tx_en <= 1'b0;
               if (cnt == '0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 40-cycle frame (4 clk/bit, 10 bits).
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int FRAME   = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  gnt;
   logic        tx_en;
   logic [7:0]  tx_data;
   logic        busy;
   logic [1:0]  cur_id;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   logic [3:0] gnt_seen;
   logic       txen_seen;

   uart_tx_arbiter #(
      .NUM_REQ(NUM_REQ), .CLKS_PER_BIT(4), .FRAME_BITS(10), .GUARD_CYCLES(0)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .gnt(gnt), .tx_en(tx_en), .tx_data(tx_data), .busy(busy), .cur_id(cur_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      gnt_seen  = gnt_seen | gnt;
      txen_seen = txen_seen | tx_en;
   endtask

   task automatic do_reset();
      req = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_txen(input int budget, output int at);
      at = -1;
      for (int k = 0; k < budget; k++) begin
         tick();
         if (tx_en) begin
            at = cyc;
            break;
         end
      end
      check("txen_arrived", {31'b0, at >= 0}, 32'd1);
   endtask

   task automatic wait_idle();
      int k;
      for (k = 0; k < 100; k++) begin
         if (!busy) break;
         tick();
      end
      check("busy_drop", {31'b0, busy}, 32'd0);
   endtask

   task automatic expect_grant(input string tag, input int budget, input logic [3:0] exp_gnt,
                               input logic [7:0] exp_data, input int prev_at, output int at);
      wait_txen(budget, at);
      check({tag, "_gnt"}, {28'b0, gnt}, {28'b0, exp_gnt});
      check({tag, "_data"}, {24'b0, tx_data}, {24'b0, exp_data});
      check({tag, "_cur_id"}, {30'b0, cur_id}, 32'($clog2(exp_gnt + 4'd0) == 0 ? 0 : 0) +
            (exp_gnt[1] ? 1 : 0) + (exp_gnt[2] ? 2 : 0) + (exp_gnt[3] ? 3 : 0));
      if (prev_at >= 0) check({tag, "_spacing"}, at - prev_at, FRAME + 1);
   endtask

   initial begin
      int at, prev, n;
      gnt_seen  = '0;
      txen_seen = 1'b0;

      // reset state
      tick();
      tick();
      check("rst_gnt", {28'b0, gnt}, 32'h0);
      check("rst_tx_en", {31'b0, tx_en}, 32'h0);
      check("rst_tx_data", {24'b0, tx_data}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_cur_id", {30'b0, cur_id}, 32'd3);
      rst = 1'b0;
      tick();
      check("idle_no_txen", {31'b0, tx_en}, 32'h0);

      // 1: single request, one-cycle latency, busy for exactly one frame
      req_data = 32'h0000_0055;
      req = 4'b0001;
      tick();
      check("t1_tx_en", {31'b0, tx_en}, 32'd1);
      check("t1_gnt", {28'b0, gnt}, 32'h1);
      check("t1_data", {24'b0, tx_data}, 32'h55);
      check("t1_busy", {31'b0, busy}, 32'd1);
      req = '0;
      n = 0;
      for (int k = 0; k < 100; k++) begin
         if (!busy) break;
         n++;
         tick();
         if (n == 1) begin
            check("t1_txen_one_cycle", {31'b0, tx_en}, 32'd0);
            check("t1_gnt_one_cycle", {28'b0, gnt}, 32'h0);
         end
      end
      check("t1_busy_len", n, FRAME);
      check("t1_data_held", {24'b0, tx_data}, 32'h55);

      // 2: all requesting, rotation from pointer 3 after reset
      do_reset();
      req_data = 32'hA3A2_A1A0;
      req = 4'b1111;
      prev = -1;
      expect_grant("t2_g0", 3, 4'b0001, 8'hA0, prev, at); prev = at;
      expect_grant("t2_g1", 60, 4'b0010, 8'hA1, prev, at); prev = at;
      expect_grant("t2_g2", 60, 4'b0100, 8'hA2, prev, at); prev = at;
      expect_grant("t2_g3", 60, 4'b1000, 8'hA3, prev, at); prev = at;
      expect_grant("t2_g4", 60, 4'b0001, 8'hA0, prev, at);
      req = '0;
      wait_idle();

      // 3: lone requester served every frame, nobody else granted
      do_reset();
      req_data = 32'h003C_0000;
      req = 4'b0100;
      gnt_seen = '0;
      prev = -1;
      expect_grant("t3_g0", 3, 4'b0100, 8'h3C, prev, at); prev = at;
      expect_grant("t3_g1", 60, 4'b0100, 8'h3C, prev, at); prev = at;
      expect_grant("t3_g2", 60, 4'b0100, 8'h3C, prev, at);
      check("t3_only_2", {28'b0, gnt_seen}, 32'h4);

      // 4: short pulse on req[1] during WAIT is ignored
      req = '0;
      gnt_seen = '0;
      repeat (5) tick();
      txen_seen = 1'b0;
      req = 4'b0010;
      repeat (3) tick();
      req = '0;
      repeat (FRAME + 5) tick();
      check("t4_no_txen", {31'b0, txen_seen}, 32'd0);
      check("t4_no_gnt", {28'b0, gnt_seen}, 32'h0);
      check("t4_idle", {31'b0, busy}, 32'd0);

      // 5: reset mid-frame aborts the wait
      do_reset();
      req_data = 32'h0077_0011;
      req = 4'b0001;
      wait_txen(3, at);
      req = '0;
      repeat (10) tick();
      check("t5_busy_mid", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      check("t5_busy_rst", {31'b0, busy}, 32'd0);
      check("t5_cur_id_rst", {30'b0, cur_id}, 32'd3);
      rst = 1'b0;
      req = 4'b0100;
      expect_grant("t5_g", 2, 4'b0100, 8'h77, -1, at);
      req = '0;
      wait_idle();

      // 6: pointer wrap 3 -> 0 -> 3
      req_data = 32'h3300_0011;
      req = 4'b1000;
      expect_grant("t6_g3", 3, 4'b1000, 8'h33, -1, at);
      prev = at;
      req = 4'b1001;
      expect_grant("t6_g0", 60, 4'b0001, 8'h11, prev, at); prev = at;
      expect_grant("t6_g3b", 60, 4'b1000, 8'h33, prev, at);
      req = '0;
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
